// File: rtl/inst_load_rx.sv
// Program-load receiver: captures loader-streamed instruction words into local RAM,
// tracks program length and out-of-range writes, then serves a 1-cycle fetch port.
module inst_load_rx #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ap_start,
  input  logic [ADDR_W-1:0] user_inst_addr,
  input  logic [DATA_W-1:0] user_inst_write,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_inst,
  output logic              fetch_valid,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   prog_len,
  output logic              addr_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   fetch_inst_q, fetch_inst_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic                load_busy_q, load_done_q;
  logic [ADDR_W:0]     prog_len_q, prog_len_d;
  logic                addr_err_q, addr_err_d;
  logic                wr_en;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W:0]     wr_addr_ext;
  logic [ADDR_W:0]     wr_addr_plus1;
  logic                wr_in_range;
  logic                fetch_in_range;

  assign wr_addr_ext    = {1'b0, user_inst_addr};
  assign wr_addr_plus1  = wr_addr_ext + {{ADDR_W{1'b0}}, 1'b1};
  assign wr_in_range    = wr_addr_ext < DEPTH_W;
  // prog_len never exceeds DEPTH, so this also guarantees a legal RAM index
  assign fetch_in_range = {1'b0, fetch_addr} < prog_len_q;

  always_comb begin
    state_d       = state_q;
    prog_len_d    = prog_len_q;
    addr_err_d    = addr_err_q;
    fetch_valid_d = 1'b0;
    fetch_inst_d  = fetch_inst_q;
    wr_en         = 1'b0;

    case (state_q)
      IDLE, READY: begin
        if (ap_start) begin
          state_d    = LOAD;
          wr_en      = wr_in_range;
          prog_len_d = wr_in_range ? wr_addr_plus1 : '0;
          addr_err_d = !wr_in_range;
        end else if (state_q == READY && fetch_en) begin
          fetch_valid_d = 1'b1;
          fetch_inst_d  = fetch_in_range ? mem[fetch_addr[IDX_W-1:0]] : '0;
        end
      end
      LOAD: begin
        if (ap_start) begin
          wr_en = wr_in_range;
          if (!wr_in_range) begin
            addr_err_d = 1'b1;
          end else if (wr_addr_plus1 > prog_len_q) begin
            prog_len_d = wr_addr_plus1;
          end
        end else begin
          state_d = READY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      fetch_inst_q  <= '0;
      fetch_valid_q <= 1'b0;
      load_busy_q   <= 1'b0;
      load_done_q   <= 1'b0;
      prog_len_q    <= '0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_inst_q  <= fetch_inst_d;
      fetch_valid_q <= fetch_valid_d;
      load_busy_q   <= (state_d == LOAD);
      load_done_q   <= (state_d == READY);
      prog_len_q    <= prog_len_d;
      addr_err_q    <= addr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[user_inst_addr[IDX_W-1:0]] <= user_inst_write;
    end
  end

  assign fetch_inst  = fetch_inst_q;
  assign fetch_valid = fetch_valid_q;
  assign load_busy   = load_busy_q;
  assign load_done   = load_done_q;
  assign prog_len    = prog_len_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_inst_load_rx.sv
// Directed table-driven bench for inst_load_rx: one row per clock, outputs checked
// #1 after the rising edge against hand-computed values.
module tb_inst_load_rx;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              ap_start;
  logic [ADDR_W-1:0] user_inst_addr;
  logic [DATA_W-1:0] user_inst_write;
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_inst;
  logic              fetch_valid;
  logic              load_busy;
  logic              load_done;
  logic [ADDR_W:0]   prog_len;
  logic              addr_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  inst_load_rx #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ap_start       (ap_start),
    .user_inst_addr (user_inst_addr),
    .user_inst_write(user_inst_write),
    .fetch_en       (fetch_en),
    .fetch_addr     (fetch_addr),
    .fetch_inst     (fetch_inst),
    .fetch_valid    (fetch_valid),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .prog_len       (prog_len),
    .addr_err       (addr_err)
  );

  typedef struct {
    logic              rst;
    logic              ap;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              fe;
    logic [ADDR_W-1:0] faddr;
    logic              e_valid;
    logic [DATA_W-1:0] e_inst;
    logic              e_busy;
    logic              e_done;
    logic [ADDR_W:0]   e_len;
    logic              e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int unsigned idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int unsigned idx);
    rst             = v.rst;
    ap_start        = v.ap;
    user_inst_addr  = v.addr;
    user_inst_write = v.wdata;
    fetch_en        = v.fe;
    fetch_addr      = v.faddr;
    @(posedge clk);
    #1;
    chk("fetch_valid", idx, 32'(fetch_valid), 32'(v.e_valid));
    chk("fetch_inst",  idx, 32'(fetch_inst),  32'(v.e_inst));
    chk("load_busy",   idx, 32'(load_busy),   32'(v.e_busy));
    chk("load_done",   idx, 32'(load_done),   32'(v.e_done));
    chk("prog_len",    idx, 32'(prog_len),    32'(v.e_len));
    chk("addr_err",    idx, 32'(addr_err),    32'(v.e_err));
  endtask

  initial begin
    //                rst ap  addr   wdata     fe  faddr   val inst      bsy dn  len  err
    // reset state
    vecs.push_back('{1, 0, 12'd0,   16'h0000, 0, 12'd0,   0, 16'h0000, 0, 0, 13'd0,   0});
    vecs.push_back('{1, 1, 12'd9,   16'h9999, 1, 12'd0,   0, 16'h0000, 0, 0, 13'd0,   0});
    // fetch in IDLE ignored
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 1, 12'd0,   0, 16'h0000, 0, 0, 13'd0,   0});
    // basic load 0..3, with fetch requests ignored during LOAD
    vecs.push_back('{0, 1, 12'd0,   16'h1001, 1, 12'd2,   0, 16'h0000, 1, 0, 13'd1,   0});
    vecs.push_back('{0, 1, 12'd1,   16'h1002, 1, 12'd2,   0, 16'h0000, 1, 0, 13'd2,   0});
    vecs.push_back('{0, 1, 12'd2,   16'h1003, 0, 12'd0,   0, 16'h0000, 1, 0, 13'd3,   0});
    vecs.push_back('{0, 1, 12'd3,   16'h1004, 1, 12'd2,   0, 16'h0000, 1, 0, 13'd4,   0});
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 1, 12'd2,   0, 16'h0000, 0, 1, 13'd4,   0});
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 1, 12'd2,   1, 16'h1003, 0, 1, 13'd4,   0});
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 0, 12'd2,   0, 16'h1003, 0, 1, 13'd4,   0});
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 1, 12'd3,   1, 16'h1004, 0, 1, 13'd4,   0});
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 1, 12'd4,   1, 16'h0000, 0, 1, 13'd4,   0});
    // reload with simultaneous fetch
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 1, 12'd0,   1, 16'h1001, 0, 1, 13'd4,   0});
    vecs.push_back('{0, 1, 12'd0,   16'h2222, 1, 12'd1,   0, 16'h1001, 1, 0, 13'd1,   0});
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 0, 12'd0,   0, 16'h1001, 0, 1, 13'd1,   0});
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 1, 12'd0,   1, 16'h2222, 0, 1, 13'd1,   0});
    // out-of-range write
    vecs.push_back('{0, 1, 12'd0,   16'hAAAA, 0, 12'd0,   0, 16'h2222, 1, 0, 13'd1,   0});
    vecs.push_back('{0, 1, 12'd300, 16'hBBBB, 0, 12'd0,   0, 16'h2222, 1, 0, 13'd1,   1});
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 0, 12'd0,   0, 16'h2222, 0, 1, 13'd1,   1});
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 1, 12'd0,   1, 16'hAAAA, 0, 1, 13'd1,   1});
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 1, 12'd1,   1, 16'h0000, 0, 1, 13'd1,   1});
    // sparse / overwrite
    vecs.push_back('{0, 1, 12'd5,   16'h0005, 0, 12'd0,   0, 16'h0000, 1, 0, 13'd6,   0});
    vecs.push_back('{0, 1, 12'd2,   16'h0002, 0, 12'd0,   0, 16'h0000, 1, 0, 13'd6,   0});
    vecs.push_back('{0, 1, 12'd5,   16'h0055, 0, 12'd0,   0, 16'h0000, 1, 0, 13'd6,   0});
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 0, 12'd0,   0, 16'h0000, 0, 1, 13'd6,   0});
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 1, 12'd5,   1, 16'h0055, 0, 1, 13'd6,   0});
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 1, 12'd3,   1, 16'h1004, 0, 1, 13'd6,   0});
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 1, 12'd2,   1, 16'h0002, 0, 1, 13'd6,   0});
    // DEPTH boundary: 255 in range, 256 out of range
    vecs.push_back('{0, 1, 12'd255, 16'hFFFF, 0, 12'd0,   0, 16'h0002, 1, 0, 13'd256, 0});
    vecs.push_back('{0, 1, 12'd256, 16'h1234, 0, 12'd0,   0, 16'h0002, 1, 0, 13'd256, 1});
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 0, 12'd0,   0, 16'h0002, 0, 1, 13'd256, 1});
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 1, 12'd255, 1, 16'hFFFF, 0, 1, 13'd256, 1});
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 1, 12'd256, 1, 16'h0000, 0, 1, 13'd256, 1});
    vecs.push_back('{0, 0, 12'd0,   16'h0000, 1, 12'hFFF, 1, 16'h0000, 0, 1, 13'd256, 1});

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Reset in the 3rd load cycle; its write to addr 5 must not land.
    apply('{0, 1, 12'd0, 16'h3001, 0, 12'd0, 0, 16'h0000, 1, 0, 13'd1, 0}, 100);
    apply('{0, 1, 12'd1, 16'h3002, 0, 12'd0, 0, 16'h0000, 1, 0, 13'd2, 0}, 101);
    apply('{1, 1, 12'd5, 16'h7777, 1, 12'd0, 0, 16'h0000, 0, 0, 13'd0, 0}, 102);
    apply('{0, 0, 12'd0, 16'h0000, 1, 12'd0, 0, 16'h0000, 0, 0, 13'd0, 0}, 103);
    apply('{0, 1, 12'd0, 16'h4001, 0, 12'd0, 0, 16'h0000, 1, 0, 13'd1, 0}, 104);
    apply('{0, 1, 12'd1, 16'h4002, 0, 12'd0, 0, 16'h0000, 1, 0, 13'd2, 0}, 105);
    apply('{0, 1, 12'd2, 16'h4003, 0, 12'd0, 0, 16'h0000, 1, 0, 13'd3, 0}, 106);
    apply('{0, 1, 12'd6, 16'h4006, 0, 12'd0, 0, 16'h0000, 1, 0, 13'd7, 0}, 107);
    apply('{0, 0, 12'd0, 16'h0000, 0, 12'd0, 0, 16'h0000, 0, 1, 13'd7, 0}, 108);
    apply('{0, 0, 12'd0, 16'h0000, 1, 12'd5, 1, 16'h0055, 0, 1, 13'd7, 0}, 109);
    apply('{0, 0, 12'd0, 16'h0000, 1, 12'd2, 1, 16'h4003, 0, 1, 13'd7, 0}, 110);
    apply('{0, 0, 12'd0, 16'h0000, 1, 12'd6, 1, 16'h4006, 0, 1, 13'd7, 0}, 111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
